// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - 2-way cache tag-array controller: lookup, fill, invalidate-all
module cache_tag_ctrl #(
  parameter int IDX_W = 5,
  parameter int TAG_W = 22,
  parameter int OFS_W = 5
) (
  input  logic                     CK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [31:0]              req_addr,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic                     resp_way,
  output logic                     resp_victim_way,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt,
  output logic                     tag_CS,
  output logic                     tag_OE,
  output logic [1:0]               tag_WEB,
  output logic [IDX_W-1:0]         tag_A,
  output logic [TAG_W:0]           tag_DI,
  input  logic [2*(TAG_W+1)-1:0]   tag_DO
);

  localparam int NSETS = 1 << IDX_W;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CMP, S_WR, S_INV, S_NOP} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NSETS-1:0]   valid0_q, valid0_d;
  logic [NSETS-1:0]   valid1_q, valid1_d;
  logic [NSETS-1:0]   lru_q, lru_d;
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [TAG_W:0]     entry0, entry1;
  logic               hit0, hit1, victim;
  // The stored SRAM valid bits and the byte offset carry no information here.
  logic               ignored_bits_unused;

  assign entry0 = tag_DO[TAG_W:0];
  assign entry1 = tag_DO[2*TAG_W+1:TAG_W+1];
  assign ignored_bits_unused = entry0[TAG_W] ^ entry1[TAG_W] ^ (^req_addr[OFS_W-1:0]);

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Next-state, SRAM strobes and response; flop valid bits are authoritative over SRAM.
  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    idx_d      = idx_q;
    valid0_d   = valid0_q;
    valid1_d   = valid1_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_hit        = 1'b0;
    resp_way        = 1'b0;
    resp_victim_way = 1'b0;
    tag_CS          = 1'b0;
    tag_OE          = 1'b0;
    tag_WEB         = 2'b11;
    tag_A           = '0;
    tag_DI          = '0;

    hit0   = valid0_q[idx_q] && (entry0[TAG_W-1:0] == tag_q);
    hit1   = valid1_q[idx_q] && (entry1[TAG_W-1:0] == tag_q);
    victim = !valid0_q[idx_q] ? 1'b0 : (!valid1_q[idx_q] ? 1'b1 : lru_q[idx_q]);

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d = req_addr[31 -: TAG_W];
          idx_d = req_addr[OFS_W +: IDX_W];
          case (req_op)
            2'b00:   state_d = S_RD;
            2'b01:   state_d = S_WR;
            2'b10:   state_d = S_INV;
            default: state_d = S_NOP;
          endcase
        end
      end
      S_RD: begin
        tag_CS  = 1'b1;
        tag_OE  = 1'b1;
        tag_A   = idx_q;
        state_d = S_CMP;
      end
      S_CMP: begin
        resp_valid      = 1'b1;
        resp_victim_way = victim;
        resp_hit        = hit0 | hit1;
        resp_way        = hit0 ? 1'b0 : hit1;
        if (hit0 | hit1) begin
          lru_d[idx_q] = ~resp_way;
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
        state_d = S_IDLE;
      end
      S_WR: begin
        tag_CS          = 1'b1;
        tag_A           = idx_q;
        tag_DI          = {1'b1, tag_q};
        tag_WEB         = victim ? 2'b01 : 2'b10;
        if (victim) valid1_d[idx_q] = 1'b1;
        else        valid0_d[idx_q] = 1'b1;
        lru_d[idx_q]    = ~victim;
        resp_valid      = 1'b1;
        resp_way        = victim;
        resp_victim_way = victim;
        state_d         = S_IDLE;
      end
      S_INV: begin
        valid0_d        = '0;
        valid1_d        = '0;
        lru_d           = '0;
        resp_valid      = 1'b1;
        resp_victim_way = victim;
        state_d         = S_IDLE;
      end
      S_NOP: begin
        resp_valid      = 1'b1;
        resp_victim_way = victim;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A reset cycle drops the command: no response and no SRAM strobe.
    if (RST) begin
      resp_valid      = 1'b0;
      resp_hit        = 1'b0;
      resp_way        = 1'b0;
      resp_victim_way = 1'b0;
      tag_CS          = 1'b0;
      tag_OE          = 1'b0;
      tag_WEB         = 2'b11;
      tag_A           = '0;
      tag_DI          = '0;
    end
  end

  // State, latched request, valid/LRU and counters.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      idx_q      <= '0;
      valid0_q   <= '0;
      valid1_q   <= '0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      idx_q      <= idx_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// tb/tb_cache_tag_ctrl.sv - self-checking bench for cache_tag_ctrl with SRAM and reference model
module tb_cache_tag_ctrl;
  localparam int IDX_W = 5;
  localparam int TAG_W = 22;
  localparam int OFS_W = 5;
  localparam int NS    = 32;

  logic CK = 1'b0;
  logic RST = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_op = 2'b11;
  logic [31:0] req_addr = '0;
  logic resp_valid, resp_hit, resp_way, resp_victim_way;
  logic [31:0] hit_cnt, miss_cnt;
  logic tag_CS, tag_OE;
  logic [1:0] tag_WEB;
  logic [IDX_W-1:0] tag_A;
  logic [TAG_W:0] tag_DI;
  logic [2*(TAG_W+1)-1:0] tag_DO;

  cache_tag_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .OFS_W(OFS_W)) dut (
    .CK(CK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_victim_way(resp_victim_way), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .tag_CS(tag_CS), .tag_OE(tag_OE), .tag_WEB(tag_WEB), .tag_A(tag_A), .tag_DI(tag_DI),
    .tag_DO(tag_DO)
  );

  always #5 CK = ~CK;

  // Tag SRAM: per-way write, registered read data.
  logic [TAG_W:0] mem0 [NS];
  logic [TAG_W:0] mem1 [NS];
  logic [2*(TAG_W+1)-1:0] do_q = '0;
  logic [2*(TAG_W+1)-1:0] force_val = '0;
  logic force_en = 1'b0;
  always @(posedge CK) begin
    if (tag_CS) begin
      if (!tag_WEB[0]) mem0[tag_A] <= tag_DI;
      if (!tag_WEB[1]) mem1[tag_A] <= tag_DI;
      if (tag_OE) do_q <= {mem1[tag_A], mem0[tag_A]};
    end
  end
  assign tag_DO = force_en ? force_val : do_q;

  // Reference model: per-set way contents, valid and LRU, plus event counts.
  bit rv0 [NS];
  bit rv1 [NS];
  bit rl  [NS];
  logic [TAG_W-1:0] rt0 [NS];
  logic [TAG_W-1:0] rt1 [NS];
  int unsigned exp_hits, exp_miss;
  int errors = 0;
  int checks = 0;

  localparam logic [TAG_W-1:0] TAG_A = 22'h048D15;
  localparam logic [TAG_W-1:0] TAG_B = 22'h3FFFFF;
  localparam logic [TAG_W-1:0] TAG_C = 22'h000ABC;
  localparam logic [IDX_W-1:0] IDX_X = 5'h13;

  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
    return {t, i, 5'h00};
  endfunction

  function automatic bit ref_victim(input int ix);
    if (!rv0[ix]) return 1'b0;
    if (!rv1[ix]) return 1'b1;
    return rl[ix];
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < NS; i++) begin
      rv0[i] = 0; rv1[i] = 0; rl[i] = 0;
    end
    exp_hits = 0; exp_miss = 0;
  endtask

  task automatic ref_apply(input logic [1:0] op, input logic [31:0] addr,
                           output logic e_hit, output logic e_way, output logic e_vic, output int e_lat);
    logic [TAG_W-1:0] tg;
    int ix;
    bit h0, h1;
    tg = addr[31:32-TAG_W];
    ix = int'(addr[OFS_W+IDX_W-1:OFS_W]);
    e_vic = ref_victim(ix);
    e_hit = 1'b0; e_way = 1'b0; e_lat = 1;
    case (op)
      2'b00: begin
        h0 = rv0[ix] && rt0[ix] == tg;
        h1 = rv1[ix] && rt1[ix] == tg;
        e_hit = h0 | h1;
        e_way = h0 ? 1'b0 : h1;
        e_lat = 2;
        if (e_hit) begin rl[ix] = ~e_way; exp_hits++; end
        else exp_miss++;
      end
      2'b01: begin
        e_way = e_vic;
        if (e_vic) begin rv1[ix] = 1; rt1[ix] = tg; end
        else begin rv0[ix] = 1; rt0[ix] = tg; end
        rl[ix] = ~e_vic;
      end
      2'b10: begin
        for (int i = 0; i < NS; i++) begin rv0[i] = 0; rv1[i] = 0; rl[i] = 0; end
      end
      default: ;
    endcase
  endtask

  // Issue one command and collect what the DUT did until its response (bounded).
  logic ob_hit, ob_way, ob_vic, ob_acc;
  logic [1:0] ob_web;
  logic [IDX_W-1:0] ob_a;
  logic [TAG_W:0] ob_di;
  int ob_lat;
  bit ob_busy_ready;

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr);
    @(negedge CK);
    ob_acc = req_ready;
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(posedge CK);
    #1 req_valid = 1'b0; req_op = 2'b11;
    ob_lat = -1; ob_web = 2'b11; ob_a = '0; ob_di = '0; ob_busy_ready = 0;
    ob_hit = 1'b0; ob_way = 1'b0; ob_vic = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CK);
      ob_web &= tag_WEB;
      if (tag_WEB != 2'b11) begin ob_a = tag_A; ob_di = tag_DI; end
      if (resp_valid) begin
        ob_lat = n; ob_hit = resp_hit; ob_way = resp_way; ob_vic = resp_victim_way;
        break;
      end
      if (req_ready) ob_busy_ready = 1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CK);
    @(negedge CK);
    checks++; if (tag_CS !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", tag_CS); end
    #1 RST = 1'b0;
    ref_reset();
    @(negedge CK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 1'b0 || resp_victim_way !== 1'b0) begin
      errors++; $display("FAIL rst_resp: got %b%b%b%b want 0000", resp_valid, resp_hit, resp_way, resp_victim_way); end
    checks++; if ({tag_CS, tag_OE, tag_WEB} !== 4'b0011) begin
      errors++; $display("FAIL rst_sram: got %b want 0011", {tag_CS, tag_OE, tag_WEB}); end
    checks++; if (tag_A !== '0 || tag_DI !== '0) begin errors++; $display("FAIL rst_addr_data: got %h/%h want 0/0", tag_A, tag_DI); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_lookup_fill();
    logic eh, ew, ev; int el;
    // Cold lookup misses
    ref_apply(2'b00, 32'h1234_5660, eh, ew, ev, el);
    do_cmd(2'b00, 32'h1234_5660);
    checks++; if (ob_lat !== 2) begin errors++; $display("FAIL cold_lat: got %0d want 2", ob_lat); end
    checks++; if (ob_hit !== 1'b0 || ob_vic !== 1'b0) begin errors++; $display("FAIL cold_resp: hit %b vic %b want 0 0", ob_hit, ob_vic); end
    checks++; if (ob_web !== 2'b11) begin errors++; $display("FAIL cold_web: got %b want 11", ob_web); end
    checks++; if (ob_busy_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got 1 want 0"); end
    @(negedge CK);
    checks++; if (miss_cnt !== 32'd1) begin errors++; $display("FAIL cold_miss_cnt: got %0d want 1", miss_cnt); end
    // Fill way0
    ref_apply(2'b01, 32'h1234_5660, eh, ew, ev, el);
    do_cmd(2'b01, 32'h1234_5660);
    checks++; if (ob_lat !== 1) begin errors++; $display("FAIL fill_lat: got %0d want 1", ob_lat); end
    checks++; if (ob_web !== 2'b10 || ob_a !== 5'h13) begin errors++; $display("FAIL fill0_web_a: got %b/%h want 10/13", ob_web, ob_a); end
    checks++; if (ob_di !== {1'b1, 22'h048D15}) begin errors++; $display("FAIL fill0_di: got %h want %h", ob_di, {1'b1, 22'h048D15}); end
    checks++; if (ob_way !== 1'b0) begin errors++; $display("FAIL fill0_way: got %b want 0", ob_way); end
    // Lookup hits way0
    ref_apply(2'b00, 32'h1234_5660, eh, ew, ev, el);
    do_cmd(2'b00, 32'h1234_5660);
    checks++; if (ob_hit !== 1'b1 || ob_way !== 1'b0) begin errors++; $display("FAIL hit0: hit %b way %b want 1 0", ob_hit, ob_way); end
    @(negedge CK);
    checks++; if (hit_cnt !== 32'd1) begin errors++; $display("FAIL hit_cnt1: got %0d want 1", hit_cnt); end
    // Second fill, same set, goes to the still-invalid way1
    ref_apply(2'b01, mk_addr(TAG_B, IDX_X), eh, ew, ev, el);
    do_cmd(2'b01, mk_addr(TAG_B, IDX_X));
    checks++; if (ob_web !== 2'b01 || ob_way !== 1'b1) begin errors++; $display("FAIL fill1: web %b way %b want 01 1", ob_web, ob_way); end
    // Touch way0 so way1 becomes LRU
    ref_apply(2'b00, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b00, mk_addr(TAG_A, IDX_X));
    checks++; if (ob_hit !== 1'b1 || ob_way !== 1'b0) begin errors++; $display("FAIL rehit0: hit %b way %b want 1 0", ob_hit, ob_way); end
    checks++; if (ob_vic !== 1'b0) begin errors++; $display("FAIL rehit0_vic: got %b want 0", ob_vic); end
    // Third fill evicts the LRU way1
    ref_apply(2'b01, mk_addr(TAG_C, IDX_X), eh, ew, ev, el);
    do_cmd(2'b01, mk_addr(TAG_C, IDX_X));
    checks++; if (ob_web !== 2'b01 || ob_way !== 1'b1 || ob_vic !== 1'b1) begin
      errors++; $display("FAIL fill_lru: web %b way %b vic %b want 01 1 1", ob_web, ob_way, ob_vic); end
    // Invalidate-all, then the SRAM still holds TAG_A in way0 but it must miss
    ref_apply(2'b10, 32'h0, eh, ew, ev, el);
    do_cmd(2'b10, 32'h0);
    checks++; if (ob_lat !== 1 || ob_web !== 2'b11) begin errors++; $display("FAIL inv: lat %0d web %b want 1 11", ob_lat, ob_web); end
    ref_apply(2'b00, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b00, mk_addr(TAG_A, IDX_X));
    checks++; if (ob_hit !== 1'b0 || ob_vic !== 1'b0) begin errors++; $display("FAIL post_inv: hit %b vic %b want 0 0", ob_hit, ob_vic); end
    @(negedge CK);
    checks++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd2) begin
      errors++; $display("FAIL post_inv_cnt: got %0d/%0d want 2/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid_op();
    logic eh, ew, ev; int el;
    bit saw_resp;
    ref_apply(2'b01, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b01, mk_addr(TAG_A, IDX_X));
    @(negedge CK);
    req_valid = 1'b1; req_op = 2'b00; req_addr = mk_addr(TAG_A, IDX_X);
    @(posedge CK);
    #1 req_valid = 1'b0; req_op = 2'b11;
    @(negedge CK);
    checks++; if (tag_CS !== 1'b1) begin errors++; $display("FAIL rd_cs: got %b want 1", tag_CS); end
    RST = 1'b1;
    #1;
    checks++; if (tag_CS !== 1'b0) begin errors++; $display("FAIL midrst_cs: got %b want 0", tag_CS); end
    @(posedge CK);
    #1 RST = 1'b0;
    ref_reset();
    saw_resp = 0;
    @(negedge CK);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", req_ready); end
    for (int n = 0; n < 4; n++) begin
      if (resp_valid) saw_resp = 1;
      @(negedge CK);
    end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL midrst_resp: got 1 want 0"); end
    ref_apply(2'b00, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b00, mk_addr(TAG_A, IDX_X));
    checks++; if (ob_hit !== 1'b0 || ob_vic !== 1'b0) begin errors++; $display("FAIL midrst_valid: hit %b vic %b want 0 0", ob_hit, ob_vic); end
    @(negedge CK);
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL midrst_cnt: got %0d/%0d want 0/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_dup_hit_and_nop();
    logic eh, ew, ev; int el;
    logic [31:0] h_before, m_before;
    ref_apply(2'b01, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b01, mk_addr(TAG_A, IDX_X));
    ref_apply(2'b01, mk_addr(TAG_B, IDX_X), eh, ew, ev, el);
    do_cmd(2'b01, mk_addr(TAG_B, IDX_X));
    force_val = {1'b1, TAG_A, 1'b1, TAG_A};
    force_en = 1'b1;
    ref_apply(2'b00, mk_addr(TAG_A, IDX_X), eh, ew, ev, el);
    do_cmd(2'b00, mk_addr(TAG_A, IDX_X));
    force_en = 1'b0;
    checks++; if (ob_hit !== 1'b1 || ob_way !== 1'b0) begin errors++; $display("FAIL dup_hit: hit %b way %b want 1 0", ob_hit, ob_way); end
    @(negedge CK);
    h_before = hit_cnt; m_before = miss_cnt;
    checks++; if (h_before !== 32'(exp_hits)) begin errors++; $display("FAIL dup_cnt: got %0d want %0d", h_before, exp_hits); end
    // Both ways valid and way0 was just used, so way1 is the victim
    ref_apply(2'b11, mk_addr(TAG_C, IDX_X), eh, ew, ev, el);
    do_cmd(2'b11, mk_addr(TAG_C, IDX_X));
    checks++; if (ob_lat !== 1 || ob_hit !== 1'b0 || ob_way !== 1'b0 || ob_web !== 2'b11) begin
      errors++; $display("FAIL nop: lat %0d hit %b way %b web %b want 1 0 0 11", ob_lat, ob_hit, ob_way, ob_web); end
    checks++; if (ob_vic !== 1'b1) begin errors++; $display("FAIL nop_vic: got %b want 1", ob_vic); end
    @(negedge CK);
    checks++; if (hit_cnt !== h_before || miss_cnt !== m_before) begin
      errors++; $display("FAIL nop_cnt: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, h_before, m_before); end
    ref_apply(2'b00, mk_addr(TAG_B, IDX_X), eh, ew, ev, el);
    do_cmd(2'b00, mk_addr(TAG_B, IDX_X));
    checks++; if (ob_hit !== 1'b1 || ob_way !== 1'b1) begin errors++; $display("FAIL nop_state: hit %b way %b want 1 1", ob_hit, ob_way); end
  endtask

  task automatic test_back_to_back();
    logic eh, ew, ev; int el;
    logic [1:0] ops [3];
    ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      ref_apply(ops[k], mk_addr(TAG_C, 5'h05), eh, ew, ev, el);
      do_cmd(ops[k], mk_addr(TAG_C, 5'h05));
      checks++; if (ob_acc !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, ob_acc); end
      checks++; if (ob_lat !== el || ob_hit !== eh) begin
        errors++; $display("FAIL b2b[%0d]: lat %0d hit %b want %0d %b", k, ob_lat, ob_hit, el, eh); end
    end
  endtask

  task automatic test_random();
    logic eh, ew, ev; int el;
    logic [1:0] op;
    logic [TAG_W-1:0] tg;
    logic [IDX_W-1:0] ix;
    logic [31:0] addr;
    int r;
    for (int k = 0; k < 250; k++) begin
      r = int'($urandom_range(0, 19));
      op = (r < 10) ? 2'b00 : (r < 16) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 3))
        0: tg = TAG_A;
        1: tg = TAG_B;
        2: tg = TAG_C;
        default: tg = 22'h155555;
      endcase
      case ($urandom_range(0, 2))
        0: ix = IDX_X;
        1: ix = 5'h00;
        default: ix = 5'h1F;
      endcase
      addr = {tg, ix, 5'($urandom)};
      ref_apply(op, addr, eh, ew, ev, el);
      do_cmd(op, addr);
      checks++; if (ob_lat !== el || ob_hit !== eh || ob_way !== ew || ob_vic !== ev) begin
        errors++; $display("FAIL rnd[%0d] op %b: lat/hit/way/vic %0d %b %b %b want %0d %b %b %b",
                           k, op, ob_lat, ob_hit, ob_way, ob_vic, el, eh, ew, ev); end
      if (op == 2'b01) begin
        checks++; if (ob_web !== (ev ? 2'b01 : 2'b10) || ob_a !== ix || ob_di !== {1'b1, tg}) begin
          errors++; $display("FAIL rnd_wr[%0d]: web %b a %h di %h want %b %h %h",
                             k, ob_web, ob_a, ob_di, (ev ? 2'b01 : 2'b10), ix, {1'b1, tg}); end
      end else begin
        checks++; if (ob_web !== 2'b11) begin errors++; $display("FAIL rnd_nowr[%0d]: web %b want 11", k, ob_web); end
      end
      @(negedge CK);
      checks++; if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_miss)) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", k, hit_cnt, miss_cnt, exp_hits, exp_miss); end
    end
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin mem0[i] = '0; mem1[i] = '0; end
    test_reset();
    test_lookup_fill();
    test_reset_mid_op();
    test_dup_hit_and_nop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
